// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined RV32I control unit: opcodes, ALUOp
// encodings and the control bundle carried through the stage registers.
package ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_I   = 3'b001;
    localparam logic [2:0] ALU_LW  = 3'b010;
    localparam logic [2:0] ALU_SW  = 3'b011;
    localparam logic [2:0] ALU_BEQ = 3'b100;
    localparam logic [2:0] ALU_JAL = 3'b101;
    localparam logic [2:0] ALU_LUI = 3'b110;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
        logic alusrc;
        logic branch;
        logic jump;
        logic lui;
    } ctrl_t;

    // The bubble's ALUOp is all ones at whatever width the pipe is built with.
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: opcode to control bundle, destination and
// whether the instruction reads rs2.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned EXT_OPS = 0
) (
    input  logic [6:0]        op,
    input  logic              valid,
    input  logic [REG_AW-1:0] rd,
    output logic [ALUOP_W-1:0] aluop,
    output ctrl_t             ctrl,
    output logic [REG_AW-1:0] dec_rd,
    output logic              rs2_used
);

    always_comb begin
        aluop    = '1;
        ctrl     = BUBBLE;
        dec_rd   = '0;
        rs2_used = 1'b0;
        if (valid) begin
            case (op)
                OP_R: begin
                    aluop         = ALUOP_W'(ALU_R);
                    ctrl.regwrite = 1'b1;
                    dec_rd        = rd;
                    rs2_used      = 1'b1;
                end
                OP_I: begin
                    aluop         = ALUOP_W'(ALU_I);
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    dec_rd        = rd;
                end
                OP_LW: begin
                    aluop         = ALUOP_W'(ALU_LW);
                    ctrl.regwrite = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.memread  = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    dec_rd        = rd;
                end
                OP_SW: begin
                    aluop         = ALUOP_W'(ALU_SW);
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    dec_rd        = rd;
                    rs2_used      = 1'b1;
                end
                OP_BEQ: begin
                    aluop         = ALUOP_W'(ALU_BEQ);
                    ctrl.branch   = 1'b1;
                    dec_rd        = rd;
                    rs2_used      = 1'b1;
                end
                OP_JAL: begin
                    if (EXT_OPS != 0) begin
                        aluop         = ALUOP_W'(ALU_JAL);
                        ctrl.regwrite = 1'b1;
                        ctrl.jump     = 1'b1;
                        dec_rd        = rd;
                    end
                end
                OP_LUI: begin
                    if (EXT_OPS != 0) begin
                        aluop         = ALUOP_W'(ALU_LUI);
                        ctrl.regwrite = 1'b1;
                        ctrl.alusrc   = 1'b1;
                        ctrl.lui      = 1'b1;
                        dec_rd        = rd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes in ID, carries control through ID/EX,
// EX/MEM and MEM/WB, inserts load-use bubbles and counts stall cycles.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned EXT_OPS = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         op_i,
    input  logic [REG_AW-1:0]  rs1_i,
    input  logic [REG_AW-1:0]  rs2_i,
    input  logic [REG_AW-1:0]  rd_i,
    input  logic               id_valid_i,
    input  logic               mem_stall_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic               ex_alusrc_o,
    output logic               ex_branch_o,
    output logic               ex_jump_o,
    output logic               ex_lui_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               wb_regwrite_o,
    output logic               wb_memtoreg_o,
    output logic [REG_AW-1:0]  wb_rd_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    logic [ALUOP_W-1:0] id_aluop;
    ctrl_t              id_ctrl;
    logic [REG_AW-1:0]  id_rd;
    logic               id_rs2_used;

    logic [ALUOP_W-1:0] ex_aluop_q;
    ctrl_t              ex_ctrl_q;
    logic [REG_AW-1:0]  ex_rd_q;

    logic               mem_regwrite_q;
    logic               mem_memtoreg_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [REG_AW-1:0]  mem_rd_q;

    logic               wb_regwrite_q;
    logic               wb_memtoreg_q;
    logic [REG_AW-1:0]  wb_rd_q;

    logic               hz;
    logic [CNT_W-1:0]   cnt_q;

    ctrl_decode #(
        .ALUOP_W (ALUOP_W),
        .REG_AW  (REG_AW),
        .EXT_OPS (EXT_OPS)
    ) u_decode (
        .op       (op_i),
        .valid    (id_valid_i),
        .rd       (rd_i),
        .aluop    (id_aluop),
        .ctrl     (id_ctrl),
        .dec_rd   (id_rd),
        .rs2_used (id_rs2_used)
    );

    // Once the bubble reaches EX its memread is clear, so hz self-clears after one cycle.
    assign hz = ex_ctrl_q.memread && (ex_rd_q != '0) && id_valid_i &&
                ((ex_rd_q == rs1_i) || (id_rs2_used && (ex_rd_q == rs2_i)));

    assign stall_o = rst_i && (mem_stall_i || (!flush_i && hz));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_aluop_q     <= '1;
            ex_ctrl_q      <= BUBBLE;
            ex_rd_q        <= '0;
            mem_regwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_rd_q       <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_rd_q        <= '0;
        end else if (!mem_stall_i) begin
            if (flush_i || hz) begin
                ex_aluop_q <= '1;
                ex_ctrl_q  <= BUBBLE;
                ex_rd_q    <= '0;
            end else begin
                ex_aluop_q <= id_aluop;
                ex_ctrl_q  <= id_ctrl;
                ex_rd_q    <= id_rd;
            end
            mem_regwrite_q <= ex_ctrl_q.regwrite;
            mem_memtoreg_q <= ex_ctrl_q.memtoreg;
            mem_read_q     <= ex_ctrl_q.memread;
            mem_write_q    <= ex_ctrl_q.memwrite;
            mem_rd_q       <= ex_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_memtoreg_q  <= mem_memtoreg_q;
            wb_rd_q        <= mem_rd_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (stall_o && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ex_aluop_o    = ex_aluop_q;
    assign ex_alusrc_o   = ex_ctrl_q.alusrc;
    assign ex_branch_o   = ex_ctrl_q.branch;
    assign ex_jump_o     = ex_ctrl_q.jump;
    assign ex_lui_o      = ex_ctrl_q.lui;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign wb_regwrite_o = wb_regwrite_q;
    assign wb_memtoreg_o = wb_memtoreg_q;
    assign wb_rd_o       = wb_rd_q;
    assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a vector table walks the pipe through hazards,
// freeze and flush; hand sequences cover EXT_OPS, counter saturation and reset.
module tb_ctrl_pipe;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       id_valid, mem_stall, flush;

    logic       d0_stall, d0_alusrc, d0_branch, d0_jump, d0_lui, d0_mr, d0_mw, d0_wrw, d0_m2r;
    logic [2:0] d0_alu;
    logic [4:0] d0_wrd;
    logic [15:0] d0_cnt;

    logic       d1_stall, d1_alusrc, d1_branch, d1_jump, d1_lui, d1_mr, d1_mw, d1_wrw, d1_m2r;
    logic [2:0] d1_alu;
    logic [4:0] d1_wrd;
    logic [15:0] d1_cnt;

    logic       ds_stall, ds_alusrc, ds_branch, ds_jump, ds_lui, ds_mr, ds_mw, ds_wrw, ds_m2r;
    logic [2:0] ds_alu;
    logic [4:0] ds_wrd;
    logic [2:0] ds_cnt;

    int tests = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       valid, mstall, flush;
        logic       exp_stall;
        logic [2:0] exp_alu;
        logic       exp_alusrc, exp_branch, exp_mr, exp_mw, exp_wrw;
        logic [4:0] exp_wrd;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    ctrl_pipe #(.EXT_OPS(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .id_valid_i(id_valid), .mem_stall_i(mem_stall), .flush_i(flush),
        .stall_o(d0_stall), .ex_aluop_o(d0_alu), .ex_alusrc_o(d0_alusrc),
        .ex_branch_o(d0_branch), .ex_jump_o(d0_jump), .ex_lui_o(d0_lui),
        .mem_read_o(d0_mr), .mem_write_o(d0_mw), .wb_regwrite_o(d0_wrw),
        .wb_memtoreg_o(d0_m2r), .wb_rd_o(d0_wrd), .stall_cnt_o(d0_cnt)
    );

    ctrl_pipe #(.EXT_OPS(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .id_valid_i(id_valid), .mem_stall_i(mem_stall), .flush_i(flush),
        .stall_o(d1_stall), .ex_aluop_o(d1_alu), .ex_alusrc_o(d1_alusrc),
        .ex_branch_o(d1_branch), .ex_jump_o(d1_jump), .ex_lui_o(d1_lui),
        .mem_read_o(d1_mr), .mem_write_o(d1_mw), .wb_regwrite_o(d1_wrw),
        .wb_memtoreg_o(d1_m2r), .wb_rd_o(d1_wrd), .stall_cnt_o(d1_cnt)
    );

    ctrl_pipe #(.CNT_W(3)) dut_sat (
        .clk_i(clk), .rst_i(rst_n), .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .id_valid_i(id_valid), .mem_stall_i(mem_stall), .flush_i(flush),
        .stall_o(ds_stall), .ex_aluop_o(ds_alu), .ex_alusrc_o(ds_alusrc),
        .ex_branch_o(ds_branch), .ex_jump_o(ds_jump), .ex_lui_o(ds_lui),
        .mem_read_o(ds_mr), .mem_write_o(ds_mw), .wb_regwrite_o(ds_wrw),
        .wb_memtoreg_o(ds_m2r), .wb_rd_o(ds_wrd), .stall_cnt_o(ds_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [6:0] o, input int s1, input int s2, input int d,
                          input bit v, input bit ms, input bit fl, input bit es,
                          input int ealu, input bit esrc, input bit ebr, input bit emr,
                          input bit emw, input bit ewrw, input int ewrd, input int ecnt);
        vec_t t;
        t.op = o; t.rs1 = 5'(s1); t.rs2 = 5'(s2); t.rd = 5'(d);
        t.valid = v; t.mstall = ms; t.flush = fl; t.exp_stall = es;
        t.exp_alu = 3'(ealu); t.exp_alusrc = esrc; t.exp_branch = ebr;
        t.exp_mr = emr; t.exp_mw = emw; t.exp_wrw = ewrw;
        t.exp_wrd = 5'(ewrd); t.exp_cnt = ecnt;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t t);
        op = t.op; rs1 = t.rs1; rs2 = t.rs2; rd = t.rd;
        id_valid = t.valid; mem_stall = t.mstall; flush = t.flush;
    endtask

    initial begin
        //      op   rs1 rs2 rd  v  ms fl | stl alu src br mr mw wrw wrd cnt
        addVec(R,   2,  3,  1, 1, 0, 0,   0,  0,  0, 0, 0, 0, 0,  0,  0);
        addVec(R,   3,  4,  2, 1, 0, 0,   0,  0,  0, 0, 0, 0, 0,  0,  0);
        addVec(I,   1,  0,  3, 1, 0, 0,   0,  1,  1, 0, 0, 0, 1,  1,  0);
        addVec(LW,  1,  0,  5, 1, 0, 0,   0,  2,  1, 0, 0, 0, 1,  2,  0);
        addVec(R,   5,  7,  6, 1, 0, 0,   1,  7,  0, 0, 1, 0, 1,  3,  1);
        addVec(R,   5,  7,  6, 1, 0, 0,   0,  0,  0, 0, 0, 0, 1,  5,  1);
        addVec(LW,  1,  0,  0, 1, 0, 0,   0,  2,  1, 0, 0, 0, 0,  0,  1);
        addVec(R,   0,  0,  7, 1, 0, 0,   0,  0,  0, 0, 1, 0, 1,  6,  1);
        addVec(LW,  2,  0,  8, 1, 0, 0,   0,  2,  1, 0, 0, 0, 1,  0,  1);
        addVec(SW,  3,  8,  0, 1, 0, 0,   1,  7,  0, 0, 1, 0, 1,  7,  2);
        addVec(SW,  3,  8,  0, 1, 0, 0,   0,  3,  1, 0, 0, 0, 1,  8,  2);
        addVec(LW,  1,  0, 10, 1, 0, 0,   0,  2,  1, 0, 0, 1, 0,  0,  2);
        addVec(I,   4, 10, 11, 1, 0, 0,   0,  1,  1, 0, 1, 0, 0,  0,  2);
        addVec(SW,  0,  0,  0, 1, 0, 0,   0,  3,  1, 0, 0, 0, 1, 10,  2);
        addVec(R,   1,  2, 12, 1, 0, 0,   0,  0,  0, 0, 0, 1, 1, 11,  2);
        addVec(R,   1,  2, 13, 1, 1, 0,   1,  0,  0, 0, 0, 1, 1, 11,  3);
        addVec(R,   1,  2, 13, 1, 1, 0,   1,  0,  0, 0, 0, 1, 1, 11,  4);
        addVec(R,   1,  2, 13, 1, 1, 0,   1,  0,  0, 0, 0, 1, 1, 11,  5);
        addVec(R,   1,  2, 13, 1, 1, 0,   1,  0,  0, 0, 0, 1, 1, 11,  6);
        addVec(R,   1,  2, 13, 1, 0, 0,   0,  0,  0, 0, 0, 0, 0,  0,  6);
        addVec(LW,  1,  0, 14, 1, 0, 0,   0,  2,  1, 0, 0, 0, 1, 12,  6);
        addVec(R,  14,  0, 15, 1, 0, 1,   0,  7,  0, 0, 1, 0, 1, 13,  6);
        addVec(BEQ,14,  1,  0, 1, 0, 0,   0,  4,  0, 1, 0, 0, 1, 14,  6);
        addVec(R,   0,  0,  3, 0, 0, 0,   0,  7,  0, 0, 0, 0, 0,  0,  6);
        addVec(LW,  1,  0,  4, 1, 0, 0,   0,  2,  1, 0, 0, 0, 0,  0,  6);
        addVec(R,   4,  0,  5, 0, 0, 0,   0,  7,  0, 0, 1, 0, 0,  0,  6);
        addVec(LW,  1,  0,  9, 1, 0, 0,   0,  2,  1, 0, 0, 0, 1,  4,  6);
        addVec(BEQ, 1,  9,  0, 1, 0, 0,   1,  7,  0, 0, 1, 0, 0,  0,  7);
        addVec(BEQ, 1,  9,  0, 1, 0, 0,   0,  4,  0, 1, 0, 0, 1,  9,  7);

        rst_n = 1'b0; op = R; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd1;
        id_valid = 1'b1; mem_stall = 1'b0; flush = 1'b0;
        #12;
        checkOutput("reset stall_o", 32'(d0_stall), 32'd0);
        checkOutput("reset ex_aluop", 32'(d0_alu), 32'd7);
        checkOutput("reset wb_regwrite", 32'(d0_wrw), 32'd0);
        checkOutput("reset mem_read", 32'(d0_mr), 32'd0);
        checkOutput("reset stall_cnt", 32'(d0_cnt), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d stall_o", i), 32'(d0_stall), 32'(vecs[i].exp_stall));
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d ex_aluop", i), 32'(d0_alu), 32'(vecs[i].exp_alu));
            checkOutput($sformatf("row%0d ex_alusrc", i), 32'(d0_alusrc), 32'(vecs[i].exp_alusrc));
            checkOutput($sformatf("row%0d ex_branch", i), 32'(d0_branch), 32'(vecs[i].exp_branch));
            checkOutput($sformatf("row%0d mem_read", i), 32'(d0_mr), 32'(vecs[i].exp_mr));
            checkOutput($sformatf("row%0d mem_write", i), 32'(d0_mw), 32'(vecs[i].exp_mw));
            checkOutput($sformatf("row%0d wb_regwrite", i), 32'(d0_wrw), 32'(vecs[i].exp_wrw));
            checkOutput($sformatf("row%0d wb_rd", i), 32'(d0_wrd), 32'(vecs[i].exp_wrd));
            checkOutput($sformatf("row%0d stall_cnt", i), 32'(d0_cnt), 32'(vecs[i].exp_cnt));
            @(negedge clk);
        end
        checkOutput("narrow counter after 7 stalls", 32'(ds_cnt), 32'd7);

        // jal / lui decode with and without EXT_OPS
        op = JAL; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd20; id_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("ext0 jal ex_aluop", 32'(d0_alu), 32'd7);
        checkOutput("ext0 jal ex_jump", 32'(d0_jump), 32'd0);
        checkOutput("ext1 jal ex_aluop", 32'(d1_alu), 32'd5);
        checkOutput("ext1 jal ex_jump", 32'(d1_jump), 32'd1);
        @(negedge clk);
        op = LUI; rd = 5'd21;
        @(posedge clk); #1;
        checkOutput("ext1 lui ex_aluop", 32'(d1_alu), 32'd6);
        checkOutput("ext1 lui ex_lui", 32'(d1_lui), 32'd1);
        checkOutput("ext1 lui ex_alusrc", 32'(d1_alusrc), 32'd1);
        checkOutput("ext0 lui ex_aluop", 32'(d0_alu), 32'd7);
        checkOutput("ext0 lui ex_lui", 32'(d0_lui), 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("ext1 jal wb_regwrite", 32'(d1_wrw), 32'd1);
        checkOutput("ext1 jal wb_rd", 32'(d1_wrd), 32'd20);
        checkOutput("ext0 jal wb_regwrite", 32'(d0_wrw), 32'd0);
        checkOutput("ext1 bubble ex_jump", 32'(d1_jump), 32'd0);

        // freeze pushes the wide counter to 10 and pins the narrow one at 7
        @(negedge clk);
        mem_stall = 1'b1;
        #1;
        checkOutput("freeze stall_o", 32'(d0_stall), 32'd1);
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        checkOutput("freeze stall_cnt", 32'(d0_cnt), 32'd10);
        checkOutput("narrow counter saturated", 32'(ds_cnt), 32'd7);
        checkOutput("freeze holds ext1 wb_regwrite", 32'(d1_wrw), 32'd1);

        // asynchronous reset in the middle of a freeze
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-stall reset stall_o", 32'(d0_stall), 32'd0);
        checkOutput("mid-stall reset stall_cnt", 32'(d0_cnt), 32'd0);
        checkOutput("mid-stall reset ex_aluop", 32'(d1_alu), 32'd7);
        checkOutput("mid-stall reset wb_regwrite", 32'(d1_wrw), 32'd0);
        checkOutput("mid-stall reset wb_rd", 32'(d1_wrd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised pipelined control unit for the 5-stage RV32I CPU; successor to the combinational opcode decoder. Decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB stage registers. Detects load-use hazards internally and inserts bubbles. Honours cache-miss freeze and branch flush, and keeps a saturating stall-cycle counter for performance runs.

Parameters:
ALUOP_W, 3, ALUOp field width; the bubble/default ALUOp is all ones.
REG_AW, 5, register address width.
EXT_OPS, 0, 1 enables decode of jal (1101111) and lui (0110111); 0 treats them as default.
CNT_W, 16, stall counter width.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
op_i  in  7  ID-stage opcode
rs1_i  in  REG_AW  ID-stage rs1
rs2_i  in  REG_AW  ID-stage rs2
rd_i  in  REG_AW  ID-stage rd
id_valid_i  in  1  ID holds a real instruction
mem_stall_i  in  1  cache miss; freeze the whole pipe
flush_i  in  1  branch taken; squash the ID instruction
stall_o  out  1  hold PC and IF/ID
ex_aluop_o  out  ALUOP_W  EX ALUOp
ex_alusrc_o  out  1  EX ALUSrc
ex_branch_o  out  1  EX Branch
ex_jump_o  out  1  EX jal (0 if EXT_OPS=0)
ex_lui_o  out  1  EX lui (0 if EXT_OPS=0)
mem_read_o  out  1  MEM MemRead
mem_write_o  out  1  MEM MemWrite
wb_regwrite_o  out  1  WB RegWrite
wb_memtoreg_o  out  1  WB MemtoReg
wb_rd_o  out  REG_AW  WB destination
stall_cnt_o  out  CNT_W  saturating stall-cycle count

Behaviour:
- Decode (combinational, ID):
  - r: ALUOp 000, RegWrite 1, ALUSrc 0.
  - i: ALUOp 001, RegWrite 1, ALUSrc 1.
  - lw: ALUOp 010, RegWrite 1, MemtoReg 1, MemRead 1, ALUSrc 1.
  - sw: ALUOp 011, MemWrite 1, ALUSrc 1.
  - beq: ALUOp 100, Branch 1.
  - jal (EXT_OPS): ALUOp 101, RegWrite 1, jump 1.
  - lui (EXT_OPS): ALUOp 110, RegWrite 1, ALUSrc 1, lui 1.
  - Default and id_valid_i=0: the bubble bundle (ALUOp all ones, every flag 0, rd 0).
- rs2 is used only by r, sw and beq.
- Stage registers ID/EX → EX/MEM → MEM/WB each hold the bundle plus rd. Output latency from decode: EX fields 1 cycle, MEM fields 2 cycles, WB fields 3 cycles.
- Reset (rst_i=0, async): all stage registers load the bubble bundle, stall_cnt_o=0, stall_o=0.
- Load-use hazard (hz) holds when all of the following are true:
  - EX MemRead=1, EX rd≠0, id_valid_i=1;
  - EX rd==rs1_i, or (rs2 used and EX rd==rs2_i).
- Per-cycle priority:
  1. mem_stall_i=1: all three stage registers hold; stall_o=1.
  2. Else flush_i=1: ID/EX loads the bubble; EX/MEM and MEM/WB advance; stall_o=0. Flush overrides hz.
  3. Else hz: ID/EX loads the bubble; EX/MEM and MEM/WB advance; stall_o=1 for exactly one cycle per load-use pair.
  4. Else: all stages advance with the decoded bundle; stall_o=0.
- stall_o is combinational from the current state and inputs.
- stall_cnt_o increments by 1 on every clock edge where stall_o=1. It saturates at all ones and never wraps.
- Reset mid-stall: all registers are bubbles immediately and stall_o drops on reset assertion.
- rd 0 is never flagged as a hazard. Outputs never carry X: every decode path assigns all fields.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants (r, i, lw, sw, beq, jal, lui);
  - the ALUOp encodings;
  - the control bundle struct;
  - the BUBBLE constant.
- One sub-module, ctrl_decode: the combinational opcode→bundle decoder, parametrised by EXT_OPS.
- ctrl_pipe holds the stage registers, hazard logic and counter.

Test Plan:
1. Reset with op_i=0110011, id_valid_i=1; release reset → ex_aluop_o=000 after 1 clock; wb_regwrite_o=1 after 3 clocks; stall_cnt_o=0.
2. lw rd=5, then next op r with rs1=5 → stall_o=1 for one cycle. EX then shows the bubble (ALUOp 111, flags 0), the r-type follows a cycle later, and stall_cnt_o=1.
3. lw rd=0 followed by a use of x0 → no stall. sw with rs2 == lw rd → stall. i-type with rs2 field == lw rd → no stall.
4. mem_stall_i=1 for 4 cycles with sw in MEM → mem_write_o stays 1 throughout, all stages frozen, stall_cnt_o += 4.
5. flush_i=1 together with a load-use hazard → ID/EX bubble, stall_o=0, counter unchanged.
6. EXT_OPS=0 vs 1 with op_i=1101111: EXT_OPS=0 gives bubble, ex_jump_o=0. EXT_OPS=1 gives ALUOp 101, ex_jump_o=1, and wb_regwrite_o=1 two cycles later.
